// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the skid-buffered pipeline stage.
//   state_t     : occupancy encoding of the stage (EMPTY / ONE / FULL)
//   DEF_DATA_W  : default payload width in bits
//   DEF_CNT_W   : default stall-counter width in bits
// ----------------------------------------------------------------------------
package pipe_pkg;

   // Occupancy of the stage. The fourth code (2'd3) is unused and is
   // treated as an illegal state that recovers to EMPTY.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CNT_W  = 16;

endpackage : pipe_pkg

// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg
// Two-entry skid register between a valid/ready upstream and downstream.
// All state is captured on the falling edge of clk. in_ready depends only on
// registered state, so there is no combinational path from out_ready to
// in_ready.
//
// Ports
//   clk        in   single clock, falling-edge active
//   reset      in   asynchronous, active-low reset
//   in_valid   in   upstream offers a payload
//   in_data    in   upstream payload (DATA_W bits)
//   in_nop     in   upstream payload is a bubble
//   in_ready   out  stage can accept a payload on the next falling edge
//   out_valid  out  stage holds a payload for downstream
//   out_data   out  head payload, 0 when out_valid=0
//   out_nop    out  head is a bubble, 1 when out_valid=0
//   out_ready  in   downstream accepts the head on the next falling edge
//   flush      in   discard all held payloads (highest priority)
//   clr_stats  in   zero the stall counter
//   stall_cnt  out  saturating count of edges with out_valid=1, out_ready=0
// ----------------------------------------------------------------------------
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_nop,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_nop,
   input  logic              out_ready,
   input  logic              flush,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_t              r_state;
   logic [DATA_W-1:0]   r_mainData;
   logic                r_mainNop;
   logic [DATA_W-1:0]   r_skidData;
   logic                r_skidNop;
   logic [CNT_W-1:0]    r_stallCnt;

   state_t              w_nextState;
   logic [DATA_W-1:0]   w_nextMainData;
   logic                w_nextMainNop;
   logic [DATA_W-1:0]   w_nextSkidData;
   logic                w_nextSkidNop;

   logic                w_inReady;
   logic                w_outValid;
   logic                w_accept;
   logic                w_transfer;

   // Handshake qualifiers come straight from the registered state; the
   // illegal code 2'd3 reports not-valid so nothing leaks out of it.
   assign w_inReady  = (r_state != FULL);
   assign w_outValid = (r_state == ONE) || (r_state == FULL);
   assign w_accept   = in_valid && w_inReady;
   assign w_transfer = w_outValid && out_ready;

   // Next-state and next-entry logic. Entries hold unless an event moves
   // them. A slot that becomes empty is cleared to data 0 / nop 1 so that
   // a vacant entry always looks like a bubble. flush overrides everything,
   // including an accept or transfer on the same edge.
   always_comb begin
      w_nextState    = r_state;
      w_nextMainData = r_mainData;
      w_nextMainNop  = r_mainNop;
      w_nextSkidData = r_skidData;
      w_nextSkidNop  = r_skidNop;

      case (r_state)
         EMPTY: begin
            if (w_accept) begin
               w_nextState    = ONE;
               w_nextMainData = in_data;
               w_nextMainNop  = in_nop;
            end
         end
         ONE: begin
            if (w_accept && w_transfer) begin
               w_nextMainData = in_data;
               w_nextMainNop  = in_nop;
            end else if (w_accept) begin
               w_nextState    = FULL;
               w_nextSkidData = in_data;
               w_nextSkidNop  = in_nop;
            end else if (w_transfer) begin
               w_nextState    = EMPTY;
               w_nextMainData = '0;
               w_nextMainNop  = 1'b1;
            end
         end
         FULL: begin
            if (w_transfer) begin
               w_nextState    = ONE;
               w_nextMainData = r_skidData;
               w_nextMainNop  = r_skidNop;
               w_nextSkidData = '0;
               w_nextSkidNop  = 1'b1;
            end
         end
         default: begin
            w_nextState    = EMPTY;
            w_nextMainData = '0;
            w_nextMainNop  = 1'b1;
            w_nextSkidData = '0;
            w_nextSkidNop  = 1'b1;
         end
      endcase

      if (flush) begin
         w_nextState    = EMPTY;
         w_nextMainData = '0;
         w_nextMainNop  = 1'b1;
         w_nextSkidData = '0;
         w_nextSkidNop  = 1'b1;
      end
   end

   // State and entry registers, captured on the falling edge.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= EMPTY;
         r_mainData <= '0;
         r_mainNop  <= 1'b1;
         r_skidData <= '0;
         r_skidNop  <= 1'b1;
      end else begin
         r_state    <= w_nextState;
         r_mainData <= w_nextMainData;
         r_mainNop  <= w_nextMainNop;
         r_skidData <= w_nextSkidData;
         r_skidNop  <= w_nextSkidNop;
      end
   end

   // Stall counter: counts edges where the head is offered but refused.
   // clr_stats wins over the increment; flush leaves the count alone.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         r_stallCnt <= '0;
      end else if (clr_stats) begin
         r_stallCnt <= '0;
      end else if (w_outValid && !out_ready && !(&r_stallCnt)) begin
         r_stallCnt <= r_stallCnt + 1'b1;
      end
   end

   // Outputs are forced to a bubble whenever nothing is held.
   assign in_ready  = w_inReady;
   assign out_valid = w_outValid;
   assign out_data  = w_outValid ? r_mainData : '0;
   assign out_nop   = w_outValid ? r_mainNop : 1'b1;
   assign stall_cnt = r_stallCnt;

endmodule : pipe_skid_reg
